// File: rtl/core_bus_scheduler.sv
// rtl/core_bus_scheduler.sv - maps decoded requests onto one of NUM_CORES cores over a shared bus
// One transaction at a time: strobe the owning core, wait for its ack or time out, return one response.
module core_bus_scheduler #(
  parameter int          NUM_CORES    = 4,
  parameter int          CORE_SPAN    = 16,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] ERROR_RESULT = 32'hDEAD_BEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [7:0]                instruction_i,
  input  logic [23:0]               address_i,
  input  logic [31:0]               value_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_result_o,
  output logic                      rsp_error_o,
  output logic [NUM_CORES-1:0]      core_sel_o,
  output logic [7:0]                core_instruction_o,
  output logic [23:0]               core_address_o,
  output logic [31:0]               core_value_o,
  input  logic [NUM_CORES-1:0]      core_ack_i,
  input  logic [32*NUM_CORES-1:0]   core_result_i,
  output logic [15:0]               err_count_o
);

  localparam int SHIFT = $clog2(CORE_SPAN);
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CORES-1:0]   sel_mask_q, sel_mask_d;
  logic [NUM_CORES-1:0]   core_sel_q, core_sel_d;
  logic [7:0]             instr_q, instr_d;
  logic [23:0]            addr_q, addr_d;
  logic [31:0]            value_q, value_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_result_q, rsp_result_d;
  logic                   rsp_error_q, rsp_error_d;
  logic [15:0]            err_count_q, err_count_d;

  logic [23:0]            req_idx;
  logic [NUM_CORES-1:0]   req_mask;
  logic                   ack_hit;
  logic [31:0]            ack_result;
  logic [CW-1:0]          cnt_inc;

  always_comb begin
    state_d      = state_q;
    sel_mask_d   = sel_mask_q;
    core_sel_d   = '0;
    instr_d      = instr_q;
    addr_d       = addr_q;
    value_d      = value_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    err_count_d  = err_count_q;

    // Index is taken from all 24 address bits so high addresses land out of range, never alias.
    req_idx  = address_i >> SHIFT;
    req_mask = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      req_mask[k] = (req_idx == 24'(k));
    end

    // The latched one-hot mask filters acks and results from cores that were not selected.
    ack_hit    = |(core_ack_i & sel_mask_q);
    ack_result = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (sel_mask_q[k]) begin
        ack_result = ack_result | core_result_i[32*k +: 32];
      end
    end
    cnt_inc = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          instr_d = instruction_i;
          value_d = value_i;
          addr_d  = address_i & 24'(CORE_SPAN - 1);
          if (req_idx < 24'(NUM_CORES)) begin
            sel_mask_d = req_mask;
            core_sel_d = req_mask;
            state_d    = ISSUE;
          end else begin
            rsp_result_d = ERROR_RESULT;
            rsp_error_d  = 1'b1;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (ack_hit) begin
          rsp_result_d = ack_result;
          rsp_error_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          rsp_result_d = ERROR_RESULT;
          rsp_error_d  = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_error_q && (err_count_q != 16'hFFFF)) begin
          err_count_d = err_count_q + 16'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sel_mask_q   <= '0;
      core_sel_q   <= '0;
      instr_q      <= '0;
      addr_q       <= '0;
      value_q      <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_mask_q   <= sel_mask_d;
      core_sel_q   <= core_sel_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      value_q      <= value_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      err_count_q  <= err_count_d;
    end
  end

  assign req_ready_o        = (state_q == IDLE);
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_result_o       = rsp_result_q;
  assign rsp_error_o        = rsp_error_q;
  assign core_sel_o         = core_sel_q;
  assign core_instruction_o = instr_q;
  assign core_address_o     = addr_q;
  assign core_value_o       = value_q;
  assign err_count_o        = err_count_q;

endmodule

// File: tb/tb_core_bus_scheduler.sv
// tb/tb_core_bus_scheduler.sv - randomized self-checking bench for core_bus_scheduler
module tb_core_bus_scheduler;
  localparam int NC   = 4;
  localparam int SPAN = 16;
  localparam int TO   = 8;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [7:0]        instr = '0;
  logic [23:0]       addr = '0;
  logic [31:0]       value = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_result;
  logic              rsp_error;
  logic [NC-1:0]     core_sel;
  logic [7:0]        core_instr;
  logic [23:0]       core_addr;
  logic [31:0]       core_value;
  logic [NC-1:0]     core_ack = '0;
  logic [32*NC-1:0]  core_result = '0;
  logic [15:0]       err_count;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;

  core_bus_scheduler #(.NUM_CORES(NC), .CORE_SPAN(SPAN), .TIMEOUT(TO), .ERROR_RESULT(ERRV)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .instruction_i(instr), .address_i(addr), .value_i(value),
    .rsp_valid_o(rsp_valid), .rsp_result_o(rsp_result), .rsp_error_o(rsp_error),
    .core_sel_o(core_sel), .core_instruction_o(core_instr), .core_address_o(core_addr),
    .core_value_o(core_value), .core_ack_i(core_ack), .core_result_i(core_result),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Reference: the selected core's ack counts only in WAIT cycles 2..TO+1; response lands the cycle after.
  task automatic run_txn(input logic [7:0] t_instr, input logic [23:0] t_addr, input logic [31:0] t_val,
                         input int ack_c, input logic [31:0] ack_v, input int wrong_c,
                         input logic [31:0] wrong_v, input bit hold_next, input logic [7:0] n_instr,
                         input logic [23:0] n_addr, input logic [31:0] n_val, input string tag);
    int idx, wrong, rsp_c;
    bit inr, exp_e;
    logic [31:0] exp_res;
    logic [NC-1:0] exp_sel;
    idx   = int'(t_addr / SPAN);
    inr   = (idx < NC);
    wrong = (idx + 1) % NC;
    rsp_c = inr ? 2 + TO : 1;
    exp_res = ERRV;
    exp_e   = 1'b1;
    if (inr && ack_c >= 2 && ack_c <= 1 + TO) begin
      rsp_c   = ack_c + 1;
      exp_res = ack_v;
      exp_e   = 1'b0;
    end

    req_valid = 1'b1; instr = t_instr; addr = t_addr; value = t_val;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_at_accept: got %b want 1", tag, req_ready); end
    @(posedge clk);
    for (int c = 1; c <= rsp_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold_next) begin instr = n_instr; addr = n_addr; value = n_val; end
        else req_valid = 1'b0;
      end
      exp_sel = '0;
      if (c == 1 && inr) exp_sel[idx] = 1'b1;
      checks += 6;
      if (core_sel !== exp_sel) begin errors++; $display("FAIL %s core_sel c%0d: got %b want %b", tag, c, core_sel, exp_sel); end
      if (rsp_valid !== (c == rsp_c)) begin errors++; $display("FAIL %s rsp_valid c%0d: got %b want %b", tag, c, rsp_valid, c == rsp_c); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL %s req_ready c%0d: got %b want 0", tag, c, req_ready); end
      if (core_instr !== t_instr) begin errors++; $display("FAIL %s core_instr c%0d: got %h want %h", tag, c, core_instr, t_instr); end
      if (core_addr !== (t_addr % SPAN)) begin errors++; $display("FAIL %s core_addr c%0d: got %h want %h", tag, c, core_addr, t_addr % SPAN); end
      if (core_value !== t_val) begin errors++; $display("FAIL %s core_value c%0d: got %h want %h", tag, c, core_value, t_val); end
      if (c == rsp_c) begin
        checks += 2;
        if (rsp_result !== exp_res) begin errors++; $display("FAIL %s rsp_result: got %h want %h", tag, rsp_result, exp_res); end
        if (rsp_error !== exp_e) begin errors++; $display("FAIL %s rsp_error: got %b want %b", tag, rsp_error, exp_e); end
      end
      core_ack = '0;
      for (int k = 0; k < NC; k++) core_result[32*k +: 32] = $urandom;
      if (inr) begin
        core_result[32*wrong +: 32] = wrong_v;
        if (c == wrong_c) core_ack[wrong] = 1'b1;
        if (c == ack_c) begin core_result[32*idx +: 32] = ack_v; core_ack[idx] = 1'b1; end
      end
    end
    if (exp_e && exp_err < 65535) exp_err++;
    @(negedge clk);
    core_ack = '0;
    checks += 4;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_after: got %b want 1", tag, req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s rsp_valid_after: got %b want 0", tag, rsp_valid); end
    if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL %s err_count: got %0d want %0d", tag, err_count, exp_err); end
    if (rsp_result !== exp_res) begin errors++; $display("FAIL %s result_held: got %h want %h", tag, rsp_result, exp_res); end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks += 5;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    if (core_sel !== '0) begin errors++; $display("FAIL reset core_sel: got %b want 0", core_sel); end
    if (err_count !== 16'd0) begin errors++; $display("FAIL reset err_count: got %0d want 0", err_count); end
    if ({rsp_result, rsp_error, core_instr, core_addr, core_value} !== '0) begin
      errors++; $display("FAIL reset outputs: got nonzero want 0");
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_normal();
    run_txn(8'h01, 24'h000021, 32'h12345678, 3, 32'hCAFEF00D, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "normal");
    run_txn(8'h7E, 24'h000030, 32'hA5A5A5A5, 2, 32'h0BADF00D, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "min_latency");
  endtask

  task automatic test_out_of_range();
    run_txn(8'h02, 24'h000040, 32'h11223344, 2, 32'h55555555, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "oor");
    run_txn(8'h03, 24'hFFFFF3, 32'h0, 2, 32'h5, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "oor_high");
  endtask

  task automatic test_timeout();
    run_txn(8'h04, 24'h000005, 32'h1, -1, 32'h0, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "timeout");
    run_txn(8'h05, 24'h000005, 32'h2, 9, 32'h600DCAFE, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "ack_last");
    run_txn(8'h06, 24'h000015, 32'h3, 10, 32'h77777777, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "ack_late");
    run_txn(8'h07, 24'h000025, 32'h4, 1, 32'h88888888, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "ack_in_issue");
  endtask

  task automatic test_wrong_core();
    run_txn(8'h08, 24'h000003, 32'h9, 5, 32'h22222222, 2, 32'h11111111, 0, 8'h0, 24'h0, 32'h0, "wrong_core");
  endtask

  task automatic test_back_to_back();
    run_txn(8'h10, 24'h000012, 32'hAAAA0001, 4, 32'h01010101, -1, 32'h0, 1, 8'h20, 24'h000037, 32'hBBBB0002, "b2b_first");
    run_txn(8'h20, 24'h000037, 32'hBBBB0002, 3, 32'h02020202, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; instr = 8'h31; addr = 24'h000010; value = 32'h31313131;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b0;
    #1;
    exp_err = 0;
    checks += 5;
    if (core_sel !== '0) begin errors++; $display("FAIL rst_mid core_sel: got %b want 0", core_sel); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid rsp_valid: got %b want 0", rsp_valid); end
    if (err_count !== 16'd0) begin errors++; $display("FAIL rst_mid err_count: got %0d want 0", err_count); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid req_ready: got %b want 1", req_ready); end
    if (rsp_result !== 32'h0) begin errors++; $display("FAIL rst_mid rsp_result: got %h want 0", rsp_result); end
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < TO + 4; c++) begin
      @(negedge clk);
      core_ack = (c == 1) ? 4'b0010 : 4'b0000;
      core_result[63:32] = 32'hBAD0BAD0;
      checks += 3;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid stray_rsp c%0d: got %b want 0", c, rsp_valid); end
      if (core_sel !== '0) begin errors++; $display("FAIL rst_mid stray_sel c%0d: got %b want 0", c, core_sel); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid idle c%0d: got %b want 1", c, req_ready); end
    end
    core_ack = '0;
    run_txn(8'h32, 24'h000019, 32'h32323232, 4, 32'h0F0F0F0F, -1, 32'h0, 0, 8'h0, 24'h0, 32'h0, "after_rst");
  endtask

  task automatic test_random();
    logic [23:0] a;
    for (int i = 0; i < 25; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 79));
      run_txn(8'($urandom), a, $urandom, int'($urandom_range(1, TO + 2)), $urandom,
              int'($urandom_range(1, TO + 2)), $urandom, 0, 8'h0, 24'h0, 32'h0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_out_of_range();
    test_timeout();
    test_wrong_core();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
